// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART/ALU frame sequencer: FSM state encoding,
// ALU op-code constants and a helper that sizes the inter-byte timeout counter.
package alu_uart_pkg;

    // Frame sequencer states (3-bit encoding)
    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;

    // ALU op codes understood by the downstream ALU
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    // Counter width able to hold 0..cycles; never below one bit so that a
    // disabled (cycles == 0) timer still elaborates cleanly.
    function automatic int timer_width(input int cycles);
        int w;
        if (cycles < 2) begin
            w = 1;
        end else begin
            w = $clog2(cycles + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/alu_uart_sequencer_frame_timer.sv
// Inter-byte timeout counter. Counts while enabled, restarts on clear, and
// flags expiry in the cycle the count reaches p_cycles-1. A clear in the same
// cycle suppresses expiry so that a byte arriving at the deadline is kept.
// p_cycles == 0 disables expiry entirely.
module frame_timer
    import alu_uart_pkg::*;
#(
    parameter int p_cycles = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int W         = timer_width(p_cycles);
    localparam int LIMIT_INT = (p_cycles > 0) ? (p_cycles - 1) : 0;
    localparam logic [W-1:0] LIMIT = W'(LIMIT_INT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         expire_s;

    // Expiry detection: enabled, not being cleared, and count at the limit
    always_comb begin
        expire_s = 1'b0;
        if ((p_cycles != 0) && i_enable && !i_clear && (count_q == LIMIT)) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    assign o_expire = expire_s;

    // Next count: clear wins, then restart on expiry, then count while enabled
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (expire_s) begin
            count_d = '0;
        end else if (i_enable) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_uart_sequencer.sv
// Frame sequencer between a byte-stream UART and a combinational ALU.
// Collects A, B and OP bytes, presents them to the ALU from registers,
// captures the result one cycle later and hands it to the transmitter.
// Every output comes straight from a flop.
module alu_uart_sequencer
    import alu_uart_pkg::*;
#(
    parameter int p_dataLength    = 8,
    parameter int p_opLength      = 6,
    parameter int p_timeoutCycles = 1000000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_rxData,
    input  logic                    i_rxDone,
    input  logic                    i_txBusy,
    output logic                    o_txStart,
    output logic [7:0]              o_txData,
    output logic [p_dataLength-1:0] o_aluA,
    output logic [p_dataLength-1:0] o_aluB,
    output logic [p_opLength-1:0]   o_aluOp,
    input  logic [p_dataLength-1:0] i_aluResult,
    output logic                    o_frameError,
    output logic                    o_overrun
);

    logic [2:0]              state_q,       state_d;
    logic                    tx_first_q,    tx_first_d;
    logic                    tx_start_q,    tx_start_d;
    logic [7:0]              tx_data_q,     tx_data_d;
    logic [p_dataLength-1:0] alu_a_q,       alu_a_d;
    logic [p_dataLength-1:0] alu_b_q,       alu_b_d;
    logic [p_opLength-1:0]   alu_op_q,      alu_op_d;
    logic                    frame_error_q, frame_error_d;
    logic                    overrun_q,     overrun_d;

    logic collecting_s;
    logic byte_accept_s;
    logic timer_clear_s;
    logic timer_enable_s;
    logic timer_expire_s;

    // Byte acceptance and timer control, derived from the current state
    always_comb begin
        collecting_s   = 1'b0;
        timer_enable_s = 1'b0;
        case (state_q)
            ST_WAIT_A:  begin collecting_s = 1'b1; timer_enable_s = 1'b0; end
            ST_WAIT_B:  begin collecting_s = 1'b1; timer_enable_s = 1'b1; end
            ST_WAIT_OP: begin collecting_s = 1'b1; timer_enable_s = 1'b1; end
            default:    begin collecting_s = 1'b0; timer_enable_s = 1'b0; end
        endcase
        byte_accept_s = collecting_s && i_rxDone;
        timer_clear_s = (state_q == ST_WAIT_A) || byte_accept_s;
    end

    frame_timer #(
        .p_cycles (p_timeoutCycles)
    ) u_frame_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (timer_clear_s),
        .i_enable (timer_enable_s),
        .o_expire (timer_expire_s)
    );

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_WAIT_A;
            tx_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_first_q <= tx_first_d;
        end
    end

    // FSM next-state logic; a received byte beats a timeout in the same cycle
    always_comb begin
        state_d    = state_q;
        tx_first_d = 1'b0;
        case (state_q)
            ST_WAIT_A: begin
                if (i_rxDone) state_d = ST_WAIT_B;
                else          state_d = ST_WAIT_A;
            end
            ST_WAIT_B: begin
                if (i_rxDone)            state_d = ST_WAIT_OP;
                else if (timer_expire_s) state_d = ST_WAIT_A;
                else                     state_d = ST_WAIT_B;
            end
            ST_WAIT_OP: begin
                if (i_rxDone)            state_d = ST_EXEC;
                else if (timer_expire_s) state_d = ST_WAIT_A;
                else                     state_d = ST_WAIT_OP;
            end
            ST_EXEC: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // tx_start_q high means the start pulse is on the wire now
                if (tx_start_q) begin
                    state_d    = ST_WAIT_TX;
                    tx_first_d = 1'b1;
                end else begin
                    state_d    = ST_SEND;
                end
            end
            ST_WAIT_TX: begin
                // busy may still read low in the cycle right after start
                if (tx_first_q)     state_d = ST_WAIT_TX;
                else if (!i_txBusy) state_d = ST_WAIT_A;
                else                state_d = ST_WAIT_TX;
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase
    end

    // FSM output logic: next values for every registered output
    always_comb begin
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;
        case (state_q)
            ST_WAIT_A: begin
                if (i_rxDone) alu_a_d = i_rxData[p_dataLength-1:0];
                else          alu_a_d = alu_a_q;
            end
            ST_WAIT_B: begin
                if (i_rxDone)            alu_b_d       = i_rxData[p_dataLength-1:0];
                else if (timer_expire_s) frame_error_d = 1'b1;
                else                     alu_b_d       = alu_b_q;
            end
            ST_WAIT_OP: begin
                if (i_rxDone)            alu_op_d      = i_rxData[p_opLength-1:0];
                else if (timer_expire_s) frame_error_d = 1'b1;
                else                     alu_op_d      = alu_op_q;
            end
            ST_EXEC: begin
                // Registering the start here lets it appear on the first SEND cycle
                tx_data_d                 = '0;
                tx_data_d[p_dataLength-1:0] = i_aluResult;
                tx_start_d                = !i_txBusy;
                overrun_d                 = i_rxDone;
            end
            ST_SEND: begin
                if (!tx_start_q && !i_txBusy) tx_start_d = 1'b1;
                else                          tx_start_d = 1'b0;
                overrun_d = i_rxDone;
            end
            ST_WAIT_TX: begin
                overrun_d = i_rxDone;
            end
            default: begin
                overrun_d = 1'b0;
            end
        endcase
    end

    // Output and operand registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            tx_data_q     <= 8'h00;
            tx_start_q    <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign o_aluA       = alu_a_q;
    assign o_aluB       = alu_b_q;
    assign o_aluOp      = alu_op_q;
    assign o_txData     = tx_data_q;
    assign o_txStart    = tx_start_q;
    assign o_frameError = frame_error_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer with a behavioural ALU and a
// transmitter that stays busy for 10 cycles after each start pulse.
module tb_alu_uart_sequencer;
    import alu_uart_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_res;
    logic       frame_error;
    logic       overrun;

    logic       force_busy;
    int         tx_cnt;
    int         start_pulses;
    int         fe_pulses;
    int         ov_pulses;
    int         checks;
    int         errors;
    int         base;

    alu_uart_sequencer #(
        .p_dataLength    (8),
        .p_opLength      (6),
        .p_timeoutCycles (16)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_rxData     (rx_data),
        .i_rxDone     (rx_done),
        .i_txBusy     (tx_busy),
        .o_txStart    (tx_start),
        .o_txData     (tx_data),
        .o_aluA       (alu_a),
        .o_aluB       (alu_b),
        .o_aluOp      (alu_op),
        .i_aluResult  (alu_res),
        .o_frameError (frame_error),
        .o_overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_res = alu_a + alu_b;
            OP_SUB:  alu_res = alu_a - alu_b;
            OP_AND:  alu_res = alu_a & alu_b;
            OP_OR:   alu_res = alu_a | alu_b;
            OP_XOR:  alu_res = alu_a ^ alu_b;
            OP_SRA:  alu_res = 8'($signed(alu_b) >>> alu_a[2:0]);
            OP_SRL:  alu_res = alu_b >> alu_a[2:0];
            OP_NOR:  alu_res = ~(alu_a | alu_b);
            default: alu_res = 8'h00;
        endcase
    end

    // Transmitter model: busy for 10 cycles after a start pulse
    always @(posedge clk or posedge rst) begin
        if (rst) tx_cnt <= 0;
        else if (tx_start) tx_cnt <= 10;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy = (tx_cnt != 0) || force_busy;

    // Pulse counters
    always @(posedge clk) begin
        if (tx_start)    start_pulses <= start_pulses + 1;
        if (frame_error) fe_pulses    <= fe_pulses + 1;
        if (overrun)     ov_pulses    <= ov_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one received byte for one cycle; returns in the cycle after it is sampled
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_txStart"}, 32'(tx_start), 32'd0);
        check({tag, "_txData"},  32'(tx_data),  32'd0);
        check({tag, "_aluA"},    32'(alu_a),    32'd0);
        check({tag, "_aluB"},    32'(alu_b),    32'd0);
        check({tag, "_aluOp"},   32'(alu_op),   32'd0);
        check({tag, "_fe"},      32'(frame_error), 32'd0);
        check({tag, "_ov"},      32'(overrun),  32'd0);
    endtask

    // Send a full frame and check the result timing: EXEC, then start at N+2
    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] exp_res);
        int s0;
        s0 = start_pulses;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        check({tag, "_execNoStart"}, 32'(tx_start), 32'd0);
        @(negedge clk);
        check({tag, "_start"},  32'(tx_start), 32'd1);
        check({tag, "_txData"}, 32'(tx_data),  32'(exp_res));
        @(negedge clk);
        check({tag, "_startEnd"}, 32'(tx_start), 32'd0);
        repeat (15) @(negedge clk);
        check({tag, "_onePulse"}, 32'(start_pulses - s0), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        start_pulses = 0;
        fe_pulses = 0;
        ov_pulses = 0;
        rst = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        force_busy = 1'b0;

        // 1: reset asserted mid-cycle clears outputs immediately
        #12;
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 2: ADD with operand register check
        run_frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
        check("add_aluA",  32'(alu_a),  32'h05);
        check("add_aluB",  32'(alu_b),  32'h03);
        check("add_aluOp", 32'(alu_op), 32'h20);

        // 3: SUB wraps, AND
        run_frame("sub", 8'h03, 8'h05, 8'h22, 8'hFE);
        run_frame("and", 8'h0F, 8'h33, 8'h24, 8'h03);

        // 4: timeout after A byte, operands held, then a clean frame
        base = fe_pulses;
        send_byte(8'h07);
        repeat (15) @(negedge clk);
        check("to_beforeExpiry", 32'(frame_error), 32'd0);
        @(negedge clk);
        check("to_pulse", 32'(frame_error), 32'd1);
        @(negedge clk);
        check("to_pulseEnd", 32'(frame_error), 32'd0);
        check("to_aluAHeld", 32'(alu_a), 32'h07);
        check("to_aluBHeld", 32'(alu_b), 32'h33);
        run_frame("after_to", 8'h01, 8'h01, 8'h20, 8'h02);
        check("to_onePulse", 32'(fe_pulses - base), 32'd1);

        // 5: transmitter busy holds start; byte during hold is an overrun
        force_busy = 1'b1;
        base = start_pulses;
        send_byte(8'h04);
        send_byte(8'h02);
        send_byte(8'h22);
        check("hold_exec", 32'(tx_start), 32'd0);
        repeat (3) @(negedge clk);
        send_byte(8'h55);
        check("hold_overrun", 32'(overrun), 32'd1);
        @(negedge clk);
        check("hold_overrunEnd", 32'(overrun), 32'd0);
        repeat (14) @(negedge clk);
        check("hold_noStart", 32'(start_pulses - base), 32'd0);
        force_busy = 1'b0;
        @(negedge clk);
        check("hold_start",  32'(tx_start), 32'd1);
        check("hold_txData", 32'(tx_data),  32'h02);
        @(negedge clk);
        check("hold_startEnd", 32'(tx_start), 32'd0);
        repeat (15) @(negedge clk);
        check("hold_onePulse", 32'(start_pulses - base), 32'd1);
        check("hold_ovCount",  32'(ov_pulses), 32'd1);
        run_frame("after_hold", 8'h0A, 8'h06, 8'h25, 8'h0E);

        // 6: reset mid-frame drops A and B; OP upper bits ignored
        send_byte(8'h09);
        send_byte(8'h09);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        run_frame("nor", 8'h02, 8'h02, 8'hE7, 8'hFD);
        check("nor_aluOp", 32'(alu_op), 32'h27);
        check("final_fe",  32'(fe_pulses), 32'd1);
        check("final_ov",  32'(ov_pulses), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
